branch_predict_ctrl: RTL and testbench

// - Supplies the 6-bit predicted-branch vector consumed by the branch resolution unit. Prediction comes from a PC-indexed 2-bit saturating-counter BHT.
// - Trains the BHT from resolved outcomes.
// - Sequences misprediction recovery: flushes the pipeline, then redirects fetch.
// - Sits between fetch/decode and the branch resolution unit.

---
 rtl/branch_predict_ctrl_pkg.sv | 23 ++
 rtl/branch_predict_ctrl_if.sv | 41 ++++
 rtl/branch_predict_ctrl_sat_bht.sv | 32 +++
 rtl/branch_predict_ctrl.sv | 126 ++++++++++++
 tb/tb_branch_predict_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// branch_predict_ctrl_pkg: shared types and helpers for the branch predictor slice.
//   Package bp_pkg: branch-type bit positions, controller state enum,
//   2-bit counter encodings, one-hot check and saturating step helper.
package bp_pkg;
    localparam int BT_BGEZ = 0;
    localparam int BT_BLTZ = 1;
    localparam int BT_BEQ  = 2;
    localparam int BT_BNE  = 3;
    localparam int BT_BLEZ = 4;
    localparam int BT_BGTZ = 5;
    localparam int BT_W    = 6;
    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_REDIRECT} state_t;
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;
    function automatic logic is_onehot(input logic [BT_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        return up ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
    endfunction
endpackage

// File: rtl/branch_predict_ctrl_if.sv
// branch_predict_ctrl_if: bus between decode/resolution side (master) and the predictor (slave).
//   Lookup: pred_req, pred_pc, pred_type -> pred_out, pred_valid
//   Resolve: res_valid, res_pc, res_taken, wrong_taken, wrong_not_taken
//   Recovery: flush, redirect, redirect_sel, busy
//   Optional (BP_STATS_EN): stat_resolved, stat_mispred
interface branch_predict_ctrl_if;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic [5:0]  pred_type;
    logic [5:0]  pred_out;
    logic        pred_valid;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [5:0]  res_taken;
    logic [5:0]  wrong_taken;
    logic [5:0]  wrong_not_taken;
    logic        flush;
    logic        redirect;
    logic        redirect_sel;
    logic        busy;
`ifdef BP_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;
`endif
    modport master (
`ifdef BP_STATS_EN
        input  stat_resolved, stat_mispred,
`endif
        output pred_req, pred_pc, pred_type, res_valid, res_pc, res_taken,
               wrong_taken, wrong_not_taken,
        input  pred_out, pred_valid, flush, redirect, redirect_sel, busy
    );
    modport slave (
`ifdef BP_STATS_EN
        output stat_resolved, stat_mispred,
`endif
        input  pred_req, pred_pc, pred_type, res_valid, res_pc, res_taken,
               wrong_taken, wrong_not_taken,
        output pred_out, pred_valid, flush, redirect, redirect_sel, busy
    );
endinterface

// File: rtl/branch_predict_ctrl_sat_bht.sv
// bp_sat_bht: 2**IDX_W x 2-bit saturating-counter branch history table.
//   clk, rst_n        : clock, async active-low reset (all entries -> CNT_INIT)
//   rd_en, rd_idx     : registered read port -> rd_cnt next cycle
//   wr_en, wr_idx, up : saturating increment (up=1) or decrement of one entry
// A read and write to the same entry in one cycle returns the pre-update value.
module bp_sat_bht
    import bp_pkg::*;
#(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = WNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             up
);
    logic [1:0] mem [2**IDX_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IDX_W; i++) mem[i] <= CNT_INIT;
            rd_cnt <= SNT;
        end else begin
            if (rd_en) rd_cnt <= mem[rd_idx];
            if (wr_en) mem[wr_idx] <= sat_step(mem[wr_idx], up);
        end
    end
endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: BHT-based branch predictor with mispredict recovery sequencer.
//   clk, rst_n : clock, async active-low reset
//   bus        : branch_predict_ctrl_if.slave (lookup, resolve, recovery outputs)
// Optional feature macro: BP_STATS_EN adds stat_resolved / stat_mispred counters.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int         IDX_W     = 4,
    parameter int         FLUSH_CYC = 2,
    parameter logic [1:0] CNT_INIT  = WNT
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_predict_ctrl_if.slave bus
);
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYC - 1);

    state_t     state, next_state;
    logic [3:0] cnt;
    logic       sel;
    logic       mispredict, lookup;
    logic [1:0] rd_cnt;
    logic [5:0] type_q;
    logic       valid_q;
    logic       flush_d, redirect_d, sel_d, busy_d;
    logic       flush_q, redirect_q, sel_q, busy_q;
    logic       unused;

    assign unused     = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0],
                          bus.res_pc[31:IDX_W+2], bus.res_pc[1:0]};
    assign mispredict = bus.res_valid & (|bus.wrong_taken | |bus.wrong_not_taken);
    assign lookup     = bus.pred_req & (state == ST_IDLE);

    bp_sat_bht #(.IDX_W(IDX_W), .CNT_INIT(CNT_INIT)) u_bht (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_en  (lookup),
        .rd_idx (bus.pred_pc[IDX_W+1:2]),
        .rd_cnt (rd_cnt),
        .wr_en  (bus.res_valid),
        .wr_idx (bus.res_pc[IDX_W+1:2]),
        .up     (|bus.res_taken)
    );

    // type_q holds the accepted one-hot type (0 otherwise), so masking the
    // registered counter MSB with it yields pred_out without extra logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            type_q  <= '0;
        end else begin
            valid_q <= lookup;
            type_q  <= (lookup && is_onehot(bus.pred_type)) ? bus.pred_type : '0;
        end
    end

    assign bus.pred_out   = type_q & {6{rd_cnt[1]}};
    assign bus.pred_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sel   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && mispredict) begin
                cnt <= CNT_LOAD;
                sel <= |bus.wrong_not_taken;
            end else if (state == ST_FLUSH && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        next_state = (state == ST_IDLE)  ? (mispredict ? ST_FLUSH : ST_IDLE) :
                     (state == ST_FLUSH) ? ((cnt == '0) ? ST_REDIRECT : ST_FLUSH) :
                     ST_IDLE;
    end

    // Outputs are decoded from next_state and registered, so they line up
    // with the state they describe.
    always_comb begin
        flush_d    = next_state == ST_FLUSH;
        redirect_d = next_state == ST_REDIRECT;
        busy_d     = next_state != ST_IDLE;
        sel_d      = redirect_d & sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            sel_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.flush        = flush_q;
    assign bus.redirect     = redirect_q;
    assign bus.redirect_sel = sel_q;
    assign bus.busy         = busy_q;

`ifdef BP_STATS_EN
    logic [31:0] n_resolved, n_mispred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_resolved <= '0;
            n_mispred  <= '0;
        end else begin
            if (bus.res_valid) n_resolved <= n_resolved + 32'd1;
            if (state == ST_IDLE && mispredict) n_mispred <= n_mispred + 32'd1;
        end
    end

    assign bus.stat_resolved = n_resolved;
    assign bus.stat_mispred  = n_mispred;
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed self-checking bench for branch_predict_ctrl (FLUSH_CYC=2, IDX_W=4).
module tb_branch_predict_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl_if bus ();

    branch_predict_ctrl #(.IDX_W(4), .FLUSH_CYC(2), .CNT_INIT(2'b01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.pred_req        = 1'b0;
        bus.pred_pc         = '0;
        bus.pred_type       = '0;
        bus.res_valid       = 1'b0;
        bus.res_pc          = '0;
        bus.res_taken       = '0;
        bus.wrong_taken     = '0;
        bus.wrong_not_taken = '0;
    endtask

    task automatic look(input logic [31:0] pc, input logic [5:0] ty);
        bus.pred_req  = 1'b1;
        bus.pred_pc   = pc;
        bus.pred_type = ty;
        tick();
        bus.pred_req  = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [5:0] tk,
                           input logic [5:0] wt, input logic [5:0] wnt);
        bus.res_valid       = 1'b1;
        bus.res_pc          = pc;
        bus.res_taken       = tk;
        bus.wrong_taken     = wt;
        bus.wrong_not_taken = wnt;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        tick();
        chk("rst_pred_out", 32'(bus.pred_out), 32'h0);
        chk("rst_pred_valid", 32'(bus.pred_valid), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_redirect", 32'(bus.redirect), 32'h0);
        chk("rst_sel", 32'(bus.redirect_sel), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        tick();

        // Cold lookup: counter 01 -> not taken
        look(32'h40, 6'b000100);
        chk("cold_out", 32'(bus.pred_out), 32'h0);
        chk("cold_valid", 32'(bus.pred_valid), 32'h1);
        tick();
        chk("noreq_valid", 32'(bus.pred_valid), 32'h0);
        chk("noreq_out", 32'(bus.pred_out), 32'h0);

        // Training: 01 -> 10 -> 11
        resolve(32'h40, 6'b000100, 6'b0, 6'b0);
        tick();
        tick();
        clr();
        look(32'h40, 6'b000100);
        chk("trained_out", 32'(bus.pred_out), 32'h04);
        // Third taken stays 11, one not-taken -> 10 (still taken)
        resolve(32'h40, 6'b000100, 6'b0, 6'b0);
        tick();
        resolve(32'h40, 6'b000000, 6'b0, 6'b0);
        tick();
        clr();
        look(32'h40, 6'b000100);
        chk("sat_hi_out", 32'(bus.pred_out), 32'h04);
        look(32'h40, 6'b100000);
        chk("bgtz_out", 32'(bus.pred_out), 32'h20);
        look(32'h40, 6'b000110);
        chk("multihot_out", 32'(bus.pred_out), 32'h0);
        chk("multihot_valid", 32'(bus.pred_valid), 32'h1);
        look(32'h40, 6'b000000);
        chk("zero_type_out", 32'(bus.pred_out), 32'h0);
        chk("zero_type_valid", 32'(bus.pred_valid), 32'h1);
        // 10 -> 01
        resolve(32'h40, 6'b000000, 6'b0, 6'b0);
        tick();
        clr();
        look(32'h40, 6'b000100);
        chk("dec_out", 32'(bus.pred_out), 32'h0);
        look(32'h44, 6'b000100);
        chk("other_idx_out", 32'(bus.pred_out), 32'h0);

        // Same-index lookup + update: read-before-write
        resolve(32'h40, 6'b000100, 6'b0, 6'b0);
        look(32'h40, 6'b000100);
        clr();
        chk("rbw_old_out", 32'(bus.pred_out), 32'h0);
        chk("rbw_old_valid", 32'(bus.pred_valid), 32'h1);
        look(32'h40, 6'b000100);
        chk("rbw_new_out", 32'(bus.pred_out), 32'h04);

        // Mispredict not-taken -> flush N+1..N+2, redirect N+3, idle N+4
        resolve(32'h48, 6'b001000, 6'b0, 6'b001000);
        tick();
        clr();
        chk("mp1_flush_n1", 32'(bus.flush), 32'h1);
        chk("mp1_busy_n1", 32'(bus.busy), 32'h1);
        chk("mp1_redir_n1", 32'(bus.redirect), 32'h0);
        bus.pred_req  = 1'b1;
        bus.pred_pc   = 32'h40;
        bus.pred_type = 6'b000100;
        tick();
        bus.pred_req  = 1'b0;
        chk("mp1_ignored_req", 32'(bus.pred_valid), 32'h0);
        chk("mp1_flush_n2", 32'(bus.flush), 32'h1);
        tick();
        chk("mp1_flush_n3", 32'(bus.flush), 32'h0);
        chk("mp1_redir_n3", 32'(bus.redirect), 32'h1);
        chk("mp1_sel_n3", 32'(bus.redirect_sel), 32'h1);
        chk("mp1_busy_n3", 32'(bus.busy), 32'h1);
        tick();
        chk("mp1_busy_n4", 32'(bus.busy), 32'h0);
        chk("mp1_redir_n4", 32'(bus.redirect), 32'h0);
        chk("mp1_sel_n4", 32'(bus.redirect_sel), 32'h0);

        // Mispredict during FLUSH: ignored for recovery, still trains BHT
        resolve(32'h4C, 6'b000000, 6'b000001, 6'b0);
        tick();
        resolve(32'h50, 6'b000001, 6'b000001, 6'b0);
        chk("mp2_flush_m1", 32'(bus.flush), 32'h1);
        tick();
        clr();
        chk("mp2_flush_m2", 32'(bus.flush), 32'h1);
        tick();
        chk("mp2_redir_m3", 32'(bus.redirect), 32'h1);
        chk("mp2_sel_m3", 32'(bus.redirect_sel), 32'h0);
        chk("mp2_flush_m3", 32'(bus.flush), 32'h0);
        tick();
        chk("mp2_busy_m4", 32'(bus.busy), 32'h0);
        chk("mp2_redir_m4", 32'(bus.redirect), 32'h0);
        tick();
        chk("mp2_single_redir", 32'(bus.redirect), 32'h0);
        chk("mp2_flush_m5", 32'(bus.flush), 32'h0);
        look(32'h50, 6'b000001);
        chk("mp2_trained_out", 32'(bus.pred_out), 32'h01);
        look(32'h4C, 6'b000001);
        chk("mp2_dec_out", 32'(bus.pred_out), 32'h0);

        // Reset mid-FLUSH
        look(32'h40, 6'b000100);
        chk("pre_rst_out", 32'(bus.pred_out), 32'h04);
        resolve(32'h60, 6'b000000, 6'b000010, 6'b0);
        tick();
        clr();
        chk("mid_flush", 32'(bus.flush), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_flush", 32'(bus.flush), 32'h0);
        chk("async_busy", 32'(bus.busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(bus.busy), 32'h0);
        look(32'h40, 6'b000100);
        chk("post_rst_out", 32'(bus.pred_out), 32'h0);
        chk("post_rst_valid", 32'(bus.pred_valid), 32'h1);
        look(32'h50, 6'b000001);
        chk("post_rst_out2", 32'(bus.pred_out), 32'h0);

`ifdef BP_STATS_EN
        chk("stat_res_rst", bus.stat_resolved, 32'd0);
        chk("stat_mp_rst", bus.stat_mispred, 32'd0);
`endif
        // Five resolves, two accepted mispredicts; both vectors set -> sel=1
        resolve(32'h100, 6'b000001, 6'b0, 6'b0);
        tick();
        resolve(32'h104, 6'b000010, 6'b000001, 6'b000010);
        tick();
        resolve(32'h108, 6'b000000, 6'b000100, 6'b0);
        tick();
        clr();
        tick();
        chk("both_redir", 32'(bus.redirect), 32'h1);
        chk("both_sel", 32'(bus.redirect_sel), 32'h1);
        tick();
        resolve(32'h10C, 6'b000000, 6'b001000, 6'b0);
        tick();
        clr();
        tick();
        tick();
        chk("wt_sel", 32'(bus.redirect_sel), 32'h0);
        chk("wt_redir", 32'(bus.redirect), 32'h1);
        tick();
        resolve(32'h110, 6'b000000, 6'b0, 6'b0);
        tick();
        clr();
        chk("stats_busy", 32'(bus.busy), 32'h0);
`ifdef BP_STATS_EN
        chk("stat_resolved", bus.stat_resolved, 32'd5);
        chk("stat_mispred", bus.stat_mispred, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
